// File: rtl/reg_dump_if.sv
// Signal bundle between reg_dump and its environment: dump control,
// register-file read port and the captured-word output stream.
interface reg_dump_if;
  logic        start;
  logic        abort;
  logic        rf_ena;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  // The dump engine itself.
  modport slave (
    input  start, abort, rf_data, out_ready,
    output rf_ena, rf_addr, out_valid, out_data, out_idx, out_last, busy, done
  );

  // Controller, register file and word sink.
  modport master (
    output start, abort, rf_data, out_ready,
    input  rf_ena, rf_addr, out_valid, out_data, out_idx, out_last, busy, done
  );
endinterface

// File: rtl/reg_dump.sv
// Walks register indices FIRST_REG..LAST_REG once per start request and
// streams each value out through a valid/ready holding register.
module reg_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic      DMP_clk,
  input  logic      DMP_rst_n,
  reg_dump_if.slave bus
);

  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_cfg_check
    $error("reg_dump: FIRST_REG <= LAST_REG <= 31 is required");
  end

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  rf_addr_q;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q;
  logic [4:0]  out_idx_q;
  logic        out_last_q;
  logic        capture;
  logic        handshake;

  assign handshake = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          idx_d   = FIRST_IDX;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          capture     = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        // Abort takes priority even when the word is accepted in the same cycle.
        if (bus.abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (handshake) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge DMP_clk or negedge DMP_rst_n) begin
    if (!DMP_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= FIRST_IDX;
      rf_addr_q   <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_idx_q   <= 5'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      // The read address is registered so it is idx during READ and frozen otherwise.
      if (state_d == S_READ) begin
        rf_addr_q <= idx_d;
      end
      if (capture) begin
        out_data_q <= bus.rf_data;
        out_idx_q  <= idx_q;
        out_last_q <= (idx_q == LAST_IDX);
      end
    end
  end

  assign bus.rf_ena    = (state_q == S_READ);
  assign bus.rf_addr   = rf_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: a full-range instance and a single-register
// instance, each fed by a behavioural register file and checked word by word.
module tb_reg_dump;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem [32];

  int checks;
  int failures;
  int done_a, done_b, exp_done_a, exp_done_b;

  word_t qa[$];
  word_t qb[$];
  word_t wa, wb;

  reg_dump_if ifa();
  reg_dump_if ifb();

  reg_dump u_dut_a (
    .DMP_clk   (clk),
    .DMP_rst_n (rst_n),
    .bus       (ifa)
  );

  reg_dump #(.FIRST_REG(5), .LAST_REG(5)) u_dut_b (
    .DMP_clk   (clk),
    .DMP_rst_n (rst_n),
    .bus       (ifb)
  );

  assign ifa.rf_data = mem[ifa.rf_addr];
  assign ifb.rf_data = mem[ifb.rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected word on every accepted output word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.out_valid && ifa.out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_word actual_idx=%0d required=no_word", ifa.out_idx);
        end else begin
          wa = qa.pop_front();
          chk("a_word", {26'd0, ifa.out_idx, ifa.out_data, ifa.out_last},
              {26'd0, wa.idx, wa.data, wa.last});
        end
      end
      if (ifa.done) begin
        done_a++;
        chk("a_done_after_last", 64'(qa.size()), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifb.out_valid && ifb.out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_word actual_idx=%0d required=no_word", ifb.out_idx);
        end else begin
          wb = qb.pop_front();
          chk("b_word", {26'd0, ifb.out_idx, ifb.out_data, ifb.out_last},
              {26'd0, wb.idx, wb.data, wb.last});
        end
      end
      if (ifb.done) begin
        done_b++;
        chk("b_done_after_last", 64'(qb.size()), 64'd0);
      end
    end
  end

  // One pass on instance A; cycle numbers count clock edges after the start-sampling edge.
  task automatic run_pass(input int stall_idx, input int stall_len, input int abort_idx,
                          input bit abort_hs, input bit rand_ready, input bit start_noise,
                          output int first_v, output int done_c);
    int cyc;
    int stall_cnt;
    bit fin;
    cyc = 0;
    stall_cnt = 0;
    first_v = -1;
    done_c = -1;
    fin = 1'b0;
    for (int i = 0; i < 32; i++) qa.push_back('{idx: 5'(i), data: mem[i], last: (i == 31)});
    if (abort_idx < 0) exp_done_a++;
    ifa.out_ready = 1'b1;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    while (!fin && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (ifa.out_valid && first_v < 0) first_v = cyc;
      if (ifa.done) done_c = cyc;
      ifa.start = 1'b0;
      if (!ifa.busy) begin
        fin = 1'b1;
      end else if (ifa.out_valid && int'(ifa.out_idx) == abort_idx) begin
        ifa.out_ready = abort_hs;
        ifa.abort = 1'b1;
        @(posedge clk); #1;
        ifa.abort = 1'b0;
        ifa.out_ready = 1'b1;
        chk("abort_to_idle", {61'd0, ifa.busy, ifa.out_valid, ifa.done}, 64'd0);
        qa.delete();
        fin = 1'b1;
      end else begin
        if (ifa.out_valid && int'(ifa.out_idx) == stall_idx && stall_cnt < stall_len) begin
          chk("stall_hold", {25'd0, ifa.out_valid, ifa.rf_ena, ifa.out_idx, ifa.out_data},
              {25'd0, 1'b1, 1'b0, 5'(stall_idx), mem[stall_idx]});
          ifa.out_ready = 1'b0;
          stall_cnt++;
        end else begin
          ifa.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (start_noise) ifa.start = 1'($urandom_range(0, 1));
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL pass_timeout actual=busy required=idle_within_1000");
      ifa.start = 1'b0;
    end
    ifa.out_ready = 1'b1;
  endtask

  initial begin
    int fv, dc, cyc, k, ab;
    bit found;
    checks = 0; failures = 0;
    done_a = 0; done_b = 0; exp_done_a = 0; exp_done_b = 0;
    for (int i = 0; i < 32; i++) mem[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.out_ready = 1'b1;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs_a", 64'({ifa.rf_ena, ifa.rf_addr, ifa.out_valid, ifa.out_data,
        ifa.out_idx, ifa.out_last, ifa.busy, ifa.done}), 64'd0);
    chk("reset_outputs_b", 64'({ifb.rf_ena, ifb.rf_addr, ifb.out_valid, ifb.out_data,
        ifb.out_idx, ifb.out_last, ifb.busy, ifb.done}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {62'd0, ifa.busy, ifa.rf_ena}, 64'd0);

    // Full dump: first word 2 cycles after the start cycle, done 64 edges after sampling.
    run_pass(-1, 0, -1, 1'b0, 1'b0, 1'b0, fv, dc);
    $display("pass full: first_valid=%0d done=%0d", fv, dc);
    chk("full_first_latency", 64'(fv), 64'd1);
    chk("full_done_cycle", 64'(dc), 64'd64);

    run_pass(3, 5, -1, 1'b0, 1'b0, 1'b0, fv, dc);
    $display("pass backpressure: done=%0d", dc);
    chk("bp_done_cycle", 64'(dc), 64'd69);

    run_pass(-1, 0, 10, 1'b0, 1'b0, 1'b0, fv, dc);
    $display("pass abort idx10 no handshake");
    chk("abort_no_done", 64'(dc), -64'sd1);

    run_pass(-1, 0, 20, 1'b1, 1'b0, 1'b0, fv, dc);
    $display("pass abort idx20 with handshake");
    chk("abort_hs_no_done", 64'(dc), -64'sd1);

    run_pass(-1, 0, -1, 1'b0, 1'b0, 1'b1, fv, dc);
    $display("pass start-noise: done=%0d", dc);
    chk("noise_done_cycle", 64'(dc), 64'd64);
    repeat (3) begin
      @(posedge clk); #1;
      chk("noise_no_restart", {63'd0, ifa.busy}, 64'd0);
    end

    ifa.start = 1'b1; ifa.abort = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    $display("start+abort in idle");
    chk("start_abort_idle", {62'd0, ifa.busy, ifa.rf_ena}, 64'd0);

    qb.push_back('{idx: 5'd5, data: mem[5], last: 1'b1});
    exp_done_b++;
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    fv = -1; dc = -1; cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (ifb.out_valid && fv < 0) fv = cyc;
      if (ifb.done) dc = cyc;
      if (!ifb.busy) break;
    end
    $display("pass single reg5: first_valid=%0d done=%0d", fv, dc);
    chk("b_first_latency", 64'(fv), 64'd1);
    chk("b_done_cycle", 64'(dc), 64'd2);

    // Reset mid-pass while word 17 is held.
    for (int i = 0; i < 32; i++) qa.push_back('{idx: 5'(i), data: mem[i], last: (i == 31)});
    ifa.out_ready = 1'b1;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    found = 1'b0;
    for (k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #1;
      if (ifa.out_valid && ifa.out_idx == 5'd17) found = 1'b1;
    end
    ifa.out_ready = 1'b0;
    chk("reached_idx17", {63'd0, found}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    $display("reset mid-pass at idx17");
    chk("midreset_outputs_a", 64'({ifa.rf_ena, ifa.rf_addr, ifa.out_valid, ifa.out_data,
        ifa.out_idx, ifa.out_last, ifa.busy, ifa.done}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    qa.delete();
    ifa.out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", {62'd0, ifa.busy, ifa.out_valid}, 64'd0);
    end

    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : -1;
      run_pass(-1, 0, ab, 1'($urandom_range(0, 1)), 1'b1, 1'b1, fv, dc);
      $display("pass random %0d: abort_idx=%0d done=%0d", p, ab, dc);
    end

    run_pass(-1, 0, -1, 1'b0, 1'b0, 1'b0, fv, dc);
    $display("pass final full: done=%0d", dc);
    chk("final_done_cycle", 64'(dc), 64'd64);

    repeat (3) @(posedge clk);
    #1;
    chk("a_done_count", 64'(done_a), 64'(exp_done_a));
    chk("b_done_count", 64'(done_b), 64'(exp_done_b));
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 The block SHALL have parameter FIRST_REG, default 0, meaning the first register index read (0..31).
REQ-002 The block SHALL have parameter LAST_REG, default 31, meaning the last register index read; FIRST_REG <= LAST_REG <= 31 is required, and any other setting is a configuration error.
REQ-003 Port DMP_clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 Port DMP_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port start  in  1  request one dump pass; sampled only in IDLE.
REQ-006 Port abort  in  1  terminate an active pass.
REQ-007 Port rf_ena  out  1  read enable to the register file read port.
REQ-008 Port rf_addr  out  5  register index presented to the register file read port.
REQ-009 Port rf_data  in  32  combinational read data returned for rf_addr in the same cycle.
REQ-010 Port out_valid  out  1  out_data/out_idx/out_last are valid.
REQ-011 Port out_ready  in  1  sink accepts the word.
REQ-012 Port out_data  out  32  captured register value.
REQ-013 Port out_idx  out  5  index of the word in out_data.
REQ-014 Port out_last  out  1  word is LAST_REG.
REQ-015 Port busy  out  1  high in every state except IDLE.
REQ-016 Port done  out  1  one-cycle pulse when a pass completes without abort.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, HOLD and DONE, with a 5-bit index counter idx.
REQ-018 IDLE: on start=1 and abort=0, the block SHALL load idx=FIRST_REG and go to READ; otherwise it stays in IDLE.
REQ-019 READ: the block SHALL drive rf_ena=1 and rf_addr=idx, and at the clock edge capture rf_data->out_data, idx->out_idx and (idx==LAST_REG)->out_last, set out_valid=1 and go to HOLD.
REQ-020 In every state other than READ, rf_ena SHALL be 0 and rf_addr SHALL hold its last value.
REQ-021 HOLD: out_valid, out_data, out_idx and out_last SHALL be held stable until out_valid&&out_ready.
REQ-022 On that handshake, the block SHALL clear out_valid; if out_last=1 it goes to DONE, otherwise idx increments by 1 and it goes to READ.
REQ-023 Throughput SHALL be one word per 2 cycles minimum; latency from the start sample to the first out_valid SHALL be 2 cycles.
REQ-024 DONE: the block SHALL assert done=1 for exactly that cycle and go to IDLE; done is 0 in all other states.
REQ-025 A start received while busy=1 SHALL be ignored and not queued.
REQ-026 A start received in the DONE cycle SHALL be ignored; a new pass begins only on a start sampled in IDLE.
REQ-027 abort=1 in READ, HOLD or DONE SHALL, at the next edge, force IDLE, clear out_valid and suppress done; no further word is emitted.
REQ-028 If abort and the handshake occur in the same cycle, the word SHALL count as accepted and abort SHALL win, so the next state is IDLE with no done pulse.
REQ-029 If start and abort are both 1 in IDLE, abort SHALL win and the block stays in IDLE.
REQ-030 idx SHALL never wrap: no increment occurs after LAST_REG; with LAST_REG=31 the final idx is 31.
REQ-031 With FIRST_REG==LAST_REG, the block SHALL emit exactly one word with out_last=1.
REQ-032 Words SHALL be emitted in strictly ascending index order, with no gaps or duplicates.

Reset
REQ-033 When DMP_rst_n=0, the block SHALL immediately, independent of the clock, enter IDLE with idx=FIRST_REG, rf_ena=0, rf_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0 and done=0.
REQ-034 A reset asserted mid-pass SHALL discard the pass, and after release no word SHALL be emitted until a new start.

Verification
REQ-035 Full dump: registers preloaded so that reg[i]=0x1000_0000+i (reg0=0), out_ready held 1, start pulse -> 32 words with idx 0..31 and data 0, 0x10000001..0x1000001F, out_last only on idx 31, done on the cycle after the last handshake, 64 cycles from start to done.
REQ-036 Backpressure: out_ready=0 for 5 cycles at idx 3 -> out_valid/out_data=0x10000003/out_idx=3 stable throughout, rf_ena=0 while held, idx 4 follows the release.
REQ-037 Abort: abort at HOLD idx 10 while out_ready=0 -> IDLE next cycle, out_valid=0, no done, busy=0; a following start restarts at idx 0.
REQ-038 Parameters FIRST_REG=LAST_REG=5 -> a single word idx 5 with out_last=1, then done.
REQ-039 Reset: DMP_rst_n low mid-pass at idx 17 -> all outputs zero without waiting for a clock edge; no words after release until start.
REQ-040 Start while busy, and start+abort in IDLE -> both ignored; the word sequence and done count are unchanged.
